// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced-button edge detect, IDLE/RUN/PAUSE FSM,
// BCD MM:SS counter driven by a clock-enable tick, and a 4-digit anode scan.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       dp,
  output logic [2:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic          r_start_q, r_clear_q, r_start_p, r_clear_p;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_s1, r_s10, r_m1, r_m10;
  logic [3:0]    w_s1_n, w_s10_n, w_m1_n, w_m10_n;
  logic          r_roll;
  logic          w_run_go, w_tick, w_wrap_all;
  logic [3:0]    r_an, r_digit;
  logic          r_dp;
  logic [2:0]    r_led;

  // Press pulses are registered so a rise sampled at edge n acts at edge n+1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_clear_q <= 1'b0;
      r_start_p <= 1'b0;
      r_clear_p <= 1'b0;
    end else begin
      r_start_q <= btn_start;
      r_clear_q <= btn_clear;
      r_start_p <= btn_start & ~r_start_q;
      r_clear_p <= btn_clear & ~r_clear_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_clear_p) begin
      w_state_nxt = ST_IDLE;
    end else if (r_start_p) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // A press leaving RUN freezes the prescaler, so a tick due that cycle is dropped
  assign w_run_go   = (r_state == ST_RUN) & ~r_start_p & ~r_clear_p;
  assign w_tick     = w_run_go & (r_pre == PRE_MAX);
  assign w_wrap_all = w_tick & (r_s1 == 4'd9) & (r_s10 == 4'd5) &
                      (r_m1 == 4'd9) & (r_m10 == 4'd9);

  always_comb begin
    w_s1_n  = r_s1;
    w_s10_n = r_s10;
    w_m1_n  = r_m1;
    w_m10_n = r_m10;
    if (w_tick) begin
      if (r_s1 >= 4'd9) begin
        w_s1_n = 4'd0;
        if (r_s10 >= 4'd5) begin
          w_s10_n = 4'd0;
          if (r_m1 >= 4'd9) begin
            w_m1_n = 4'd0;
            if (r_m10 >= 4'd9) begin
              w_m10_n = 4'd0;
            end else begin
              w_m10_n = r_m10 + 4'd1;
            end
          end else begin
            w_m1_n = r_m1 + 4'd1;
          end
        end else begin
          w_s10_n = r_s10 + 4'd1;
        end
      end else begin
        w_s1_n = r_s1 + 4'd1;
      end
    end else begin
      w_s1_n = r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_s1    <= 4'd0;
      r_s10   <= 4'd0;
      r_m1    <= 4'd0;
      r_m10   <= 4'd0;
      r_roll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_clear_p || r_state == ST_IDLE) begin
        r_pre <= '0;
      end else if (w_run_go) begin
        r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
      end
      if (r_clear_p) begin
        r_s1   <= 4'd0;
        r_s10  <= 4'd0;
        r_m1   <= 4'd0;
        r_m10  <= 4'd0;
        r_roll <= 1'b0;
      end else begin
        r_s1  <= w_s1_n;
        r_s10 <= w_s10_n;
        r_m1  <= w_m1_n;
        r_m10 <= w_m10_n;
        if (w_wrap_all) begin
          r_roll <= 1'b1;
        end
      end
    end
  end

  // Scan runs free in every state; clear does not disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
      r_idx  <= 2'd0;
    end else if (r_scnt == SCAN_MAX) begin
      r_scnt <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scnt <= r_scnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= 4'b1110;
      r_digit <= 4'd0;
      r_dp    <= 1'b1;
      r_led   <= 3'b000;
    end else begin
      r_led <= {r_roll, (r_state == ST_PAUSE), (r_state == ST_RUN)};
      case (r_idx)
        2'd0: begin r_an <= 4'b1110; r_digit <= r_s1;  r_dp <= 1'b1; end
        2'd1: begin r_an <= 4'b1101; r_digit <= r_s10; r_dp <= 1'b1; end
        2'd2: begin r_an <= 4'b1011; r_digit <= r_m1;  r_dp <= 1'b0; end
        2'd3: begin r_an <= 4'b0111; r_digit <= r_m10; r_dp <= 1'b1; end
        default: begin r_an <= 4'b1110; r_digit <= 4'd0; r_dp <= 1'b1; end
      endcase
    end
  end

  assign an    = r_an;
  assign digit = r_digit;
  assign dp    = r_dp;
  assign led   = r_led;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, SCAN_DIV=4.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] an;
  logic [3:0] digit;
  logic       dp;
  logic [2:0] led;

  int n_vec;
  int n_err;

  stopwatch_ctrl #(.TICK_DIV(10), .SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .an       (an),
    .digit    (digit),
    .dp       (dp),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button high for one sampling edge; returns just after the state-change edge
  task automatic press_start();
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(1);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    step(1);
    btn_clear = 1'b0;
    step(1);
  endtask

  function automatic logic [15:0] count_of(input int secs);
    logic [15:0] v;
    v[3:0]   = 4'((secs % 10));
    v[7:4]   = 4'(((secs / 10) % 6));
    v[11:8]  = 4'(((secs / 60) % 10));
    v[15:12] = 4'(((secs / 600) % 10));
    return v;
  endfunction

  function automatic logic [15:0] dut_count();
    return {dut.r_m10, dut.r_m1, dut.r_s10, dut.r_s1};
  endfunction

  task automatic test_reset();
    logic [3:0] exp_an;
    logic       exp_dp;
    rst = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    step(2);
    n_vec++;
    if ({an, digit, dp, led} !== {4'b1110, 4'd0, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL reset_outputs: got an=%b digit=%0d dp=%b led=%b, want an=1110 digit=0 dp=1 led=000",
               an, digit, dp, led);
    end
    n_vec++;
    if ({dut.r_state, dut.r_pre, dut_count()} !== {2'd0, 4'd0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_state: got state=%0d pre=%0d count=%h, want 0 0 0000",
               dut.r_state, dut.r_pre, dut_count());
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      case (((k - 1) / 4) % 4)
        0: begin exp_an = 4'b1110; exp_dp = 1'b1; end
        1: begin exp_an = 4'b1101; exp_dp = 1'b1; end
        2: begin exp_an = 4'b1011; exp_dp = 1'b0; end
        default: begin exp_an = 4'b0111; exp_dp = 1'b1; end
      endcase
      n_vec++;
      if ({an, dp, digit, led} !== {exp_an, exp_dp, 4'd0, 3'b000}) begin
        n_err++;
        $display("FAIL scan k=%0d: got an=%b dp=%b digit=%0d led=%b, want an=%b dp=%b digit=0 led=000",
                 k, an, dp, digit, led, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_start_count();
    press_start();
    for (int t = 1; t <= 610; t++) begin
      step(1);
      n_vec++;
      if (dut_count() !== count_of(t / 10) || led !== 3'b001) begin
        n_err++;
        $display("FAIL count t=%0d: got count=%h led=%b, want count=%h led=001",
                 t, dut_count(), led, count_of(t / 10));
      end
    end
    n_vec++;
    if (dut_count() !== 16'h0101) begin
      n_err++;
      $display("FAIL count_0101: got %h, want 0101", dut_count());
    end
    press_clear();
    step(1);
    n_vec++;
    if ({dut.r_state, dut_count(), led} !== {2'd0, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL clear_after_count: got state=%0d count=%h led=%b, want 0 0000 000",
               dut.r_state, dut_count(), led);
    end
  endtask

  task automatic test_pause_resume();
    press_start();
    step(15);
    n_vec++;
    if (dut_count() !== 16'h0001) begin
      n_err++;
      $display("FAIL pause_pre: got %h, want 0001", dut_count());
    end
    // Button sampled at RUN+16, state PAUSE at RUN+17 with pre frozen at 6
    press_start();
    n_vec++;
    if ({dut.r_state, dut.r_pre} !== {2'd2, 4'd6}) begin
      n_err++;
      $display("FAIL pause_enter: got state=%0d pre=%0d, want 2 6", dut.r_state, dut.r_pre);
    end
    for (int t = 1; t <= 100; t++) begin
      step(1);
      n_vec++;
      if (dut_count() !== 16'h0001 || led !== 3'b010) begin
        n_err++;
        $display("FAIL pause_hold t=%0d: got count=%h led=%b, want 0001 010", t, dut_count(), led);
      end
    end
    press_start();
    step(3);
    n_vec++;
    if (dut_count() !== 16'h0001) begin
      n_err++;
      $display("FAIL resume_early: got %h, want 0001", dut_count());
    end
    step(1);
    n_vec++;
    if (dut_count() !== 16'h0002) begin
      n_err++;
      $display("FAIL resume_tick: got %h, want 0002", dut_count());
    end
    // Pause press lands while pre==9: the due tick must be suppressed
    step(8);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(1);
    n_vec++;
    if ({dut.r_state, dut.r_pre, dut_count()} !== {2'd2, 4'd9, 16'h0002}) begin
      n_err++;
      $display("FAIL pause_at_max: got state=%0d pre=%0d count=%h, want 2 9 0002",
               dut.r_state, dut.r_pre, dut_count());
    end
    press_start();
    step(1);
    n_vec++;
    if (dut_count() !== 16'h0003) begin
      n_err++;
      $display("FAIL resume_at_max: got %h, want 0003", dut_count());
    end
    press_clear();
  endtask

  task automatic test_rollover();
    logic [3:0] exp_d;
    logic       exp_dp;
    press_start();
    step(59990);
    n_vec++;
    if (dut_count() !== 16'h9959 || led !== 3'b001) begin
      n_err++;
      $display("FAIL reach_9959: got count=%h led=%b, want 9959 001", dut_count(), led);
    end
    press_start();
    for (int t = 0; t < 17; t++) begin
      step(1);
      case (an)
        4'b1110: begin exp_d = 4'd9; exp_dp = 1'b1; end
        4'b1101: begin exp_d = 4'd5; exp_dp = 1'b1; end
        4'b1011: begin exp_d = 4'd9; exp_dp = 1'b0; end
        4'b0111: begin exp_d = 4'd9; exp_dp = 1'b1; end
        default: begin exp_d = 4'hF; exp_dp = 1'bx; end
      endcase
      n_vec++;
      if (digit !== exp_d || dp !== exp_dp) begin
        n_err++;
        $display("FAIL display_9959 t=%0d: got an=%b digit=%0d dp=%b, want digit=%0d dp=%b",
                 t, an, digit, dp, exp_d, exp_dp);
      end
    end
    // Paused with pre=1, so the wrap tick comes 9 cycles after resume
    press_start();
    step(8);
    n_vec++;
    if (dut_count() !== 16'h9959) begin
      n_err++;
      $display("FAIL pre_roll: got %h, want 9959", dut_count());
    end
    step(1);
    n_vec++;
    if (dut_count() !== 16'h0000) begin
      n_err++;
      $display("FAIL roll_count: got %h, want 0000", dut_count());
    end
    step(1);
    n_vec++;
    if (led !== 3'b101) begin
      n_err++;
      $display("FAIL roll_led: got %b, want 101", led);
    end
    step(9);
    n_vec++;
    if (dut_count() !== 16'h0001 || led !== 3'b101) begin
      n_err++;
      $display("FAIL roll_continue: got count=%h led=%b, want 0001 101", dut_count(), led);
    end
    press_clear();
    step(1);
    n_vec++;
    if (led !== 3'b000) begin
      n_err++;
      $display("FAIL roll_clear_led: got %b, want 000", led);
    end
    for (int t = 0; t < 16; t++) begin
      step(1);
      n_vec++;
      if (digit !== 4'd0) begin
        n_err++;
        $display("FAIL clear_display t=%0d: got digit=%0d an=%b, want 0", t, digit, an);
      end
    end
  endtask

  task automatic test_start_clear();
    press_start();
    step(25);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    step(2);
    n_vec++;
    if ({dut.r_state, dut_count()} !== {2'd0, 16'h0000}) begin
      n_err++;
      $display("FAIL start_clear: got state=%0d count=%h, want 0 0000", dut.r_state, dut_count());
    end
    btn_clear = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step(1);
      n_vec++;
      if (dut.r_state !== 2'd0 || led !== 3'b000) begin
        n_err++;
        $display("FAIL held_start t=%0d: got state=%0d led=%b, want 0 000", t, dut.r_state, led);
      end
    end
    btn_start = 1'b0;
    step(2);
    press_start();
    n_vec++;
    if (dut.r_state !== 2'd1) begin
      n_err++;
      $display("FAIL repress_start: got state=%0d, want 1", dut.r_state);
    end
  endtask

  task automatic test_mid_reset();
    step(370);
    n_vec++;
    if (dut_count() !== 16'h0037) begin
      n_err++;
      $display("FAIL reach_0037: got %h, want 0037", dut_count());
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_vec++;
    if ({dut.r_state, dut.r_pre, dut_count(), an, led} !== {2'd0, 4'd0, 16'h0000, 4'b1110, 3'b000}) begin
      n_err++;
      $display("FAIL mid_reset: got state=%0d pre=%0d count=%h an=%b led=%b, want 0 0 0000 1110 000",
               dut.r_state, dut.r_pre, dut_count(), an, led);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    test_reset();
    test_start_count();
    test_pause_resume();
    test_rollover();
    test_start_clear();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
